// File: rtl/ext_mem_model_mc.sv
// Multi-channel byte-addressed external memory model for HLS co-simulation.
// Each channel serves one master port with fixed read/write latency and sub-word sizes.
module ext_mem_model_mc #(
    parameter int N_CH   = 2,
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32,
    parameter int SIZE_W = 6,
    parameter int DEPTH  = 32,
    parameter int RD_LAT = 2,
    parameter int WR_LAT = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic                     load_en,
    input  logic [ADDR_W-1:0]        load_addr,
    input  logic [7:0]               load_data,
    input  logic [N_CH-1:0]          Mout_oe_ram,
    input  logic [N_CH-1:0]          Mout_we_ram,
    input  logic [N_CH*ADDR_W-1:0]   Mout_addr_ram,
    input  logic [N_CH*DATA_W-1:0]   Mout_Wdata_ram,
    input  logic [N_CH*SIZE_W-1:0]   Mout_data_ram_size,
    output logic [N_CH*DATA_W-1:0]   M_Rdata_ram,
    output logic [N_CH-1:0]          M_DataRdy,
    output logic                     err_flag
);

    localparam int NB      = DATA_W / 8;
    localparam int AW1     = ADDR_W + 1;
    localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    logic [7:0]        mem_r       [DEPTH];
    state_t            state_r     [N_CH];
    state_t            state_nxt_s [N_CH];
    logic [CNT_W-1:0]  cnt_r       [N_CH];
    logic [CNT_W-1:0]  cnt_nxt_s   [N_CH];
    logic [CNT_W-1:0]  lat_s       [N_CH];
    logic [DATA_W-1:0] snap_r      [N_CH];
    logic [DATA_W-1:0] rd_word_s   [N_CH];
    logic [DATA_W-1:0] rdata_nxt_s [N_CH];
    logic [ADDR_W-1:0] addr_s      [N_CH];
    logic [ADDR_W-1:0] off_s       [N_CH];
    logic [SIZE_W-1:0] size_s      [N_CH];
    logic [SIZE_W-1:0] nb_s        [N_CH];
    logic [AW1-1:0]    nbw_s       [N_CH];
    logic [N_CH-1:0]   kind_r;
    logic [N_CH-1:0]   kind_nxt_s;
    logic [N_CH-1:0]   size_ok_s;
    logic [N_CH-1:0]   in_win_s;
    logic [N_CH-1:0]   accept_s;
    logic [N_CH-1:0]   err_req_s;
    logic [N_CH-1:0]   rdy_nxt_s;
    logic              err_load_s;

    // Request decode: size check, window check, acceptance and the combinational read word.
    always_comb begin
        err_load_s = load_en && ({1'b0, load_addr} >= AW1'(DEPTH));
        for (int c = 0; c < N_CH; c++) begin
            addr_s[c]    = Mout_addr_ram[c*ADDR_W +: ADDR_W];
            size_s[c]    = Mout_data_ram_size[c*SIZE_W +: SIZE_W];
            nb_s[c]      = size_s[c] >> 3;
            size_ok_s[c] = (size_s[c][2:0] == 3'd0) && (size_s[c] >= SIZE_W'(8))
                           && (32'(size_s[c]) <= DATA_W);
            // A zero byte count still has to land inside the window to count as ours.
            if (nb_s[c] == {SIZE_W{1'b0}}) begin
                nbw_s[c] = AW1'(1);
            end else begin
                nbw_s[c] = AW1'(nb_s[c]);
            end
            in_win_s[c]  = ({1'b0, addr_s[c]} >= {1'b0, base_addr})
                           && (({1'b0, addr_s[c]} + nbw_s[c]) <= ({1'b0, base_addr} + AW1'(DEPTH)));
            off_s[c]     = addr_s[c] - base_addr;
            accept_s[c]  = reset && (state_r[c] == ST_IDLE) && (Mout_oe_ram[c] ^ Mout_we_ram[c])
                           && in_win_s[c] && size_ok_s[c];
            err_req_s[c] = (state_r[c] == ST_IDLE)
                           && ((Mout_oe_ram[c] && Mout_we_ram[c])
                               || ((Mout_oe_ram[c] ^ Mout_we_ram[c]) && in_win_s[c] && !size_ok_s[c]));
            for (int i = 0; i < NB; i++) begin
                if (SIZE_W'(i) < nb_s[c]) begin
                    rd_word_s[c][8*i +: 8] = mem_r[IDX_W'(off_s[c] + ADDR_W'(i))];
                end else begin
                    rd_word_s[c][8*i +: 8] = 8'h00;
                end
            end
        end
    end

    // Per-channel FSM next state, response strobe and response data.
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            state_nxt_s[c] = state_r[c];
            cnt_nxt_s[c]   = cnt_r[c];
            kind_nxt_s[c]  = kind_r[c];
            rdy_nxt_s[c]   = 1'b0;
            rdata_nxt_s[c] = {DATA_W{1'b0}};
            lat_s[c]       = kind_r[c] ? CNT_W'(WR_LAT) : CNT_W'(RD_LAT);
            case (state_r[c])
                ST_IDLE: begin
                    if (accept_s[c]) begin
                        kind_nxt_s[c] = Mout_we_ram[c];
                        cnt_nxt_s[c]  = CNT_W'(1);
                        if ((Mout_we_ram[c] ? WR_LAT : RD_LAT) == 1) begin
                            state_nxt_s[c] = ST_RESP;
                            rdy_nxt_s[c]   = 1'b1;
                            rdata_nxt_s[c] = Mout_we_ram[c] ? {DATA_W{1'b0}} : rd_word_s[c];
                        end else begin
                            state_nxt_s[c] = ST_BUSY;
                        end
                    end else begin
                        state_nxt_s[c] = ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    cnt_nxt_s[c] = cnt_r[c] + CNT_W'(1);
                    if (cnt_r[c] == (lat_s[c] - CNT_W'(1))) begin
                        state_nxt_s[c] = ST_RESP;
                        rdy_nxt_s[c]   = 1'b1;
                        rdata_nxt_s[c] = kind_r[c] ? {DATA_W{1'b0}} : snap_r[c];
                    end else begin
                        state_nxt_s[c] = ST_BUSY;
                    end
                end
                ST_RESP: begin
                    state_nxt_s[c] = ST_IDLE;
                end
                default: begin
                    state_nxt_s[c] = ST_IDLE;
                end
            endcase
        end
    end

    // Channel state, read snapshot and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < N_CH; c++) begin
                state_r[c] <= ST_IDLE;
                cnt_r[c]   <= {CNT_W{1'b0}};
                snap_r[c]  <= {DATA_W{1'b0}};
            end
            kind_r      <= {N_CH{1'b0}};
            M_Rdata_ram <= {(N_CH*DATA_W){1'b0}};
            M_DataRdy   <= {N_CH{1'b0}};
            err_flag    <= 1'b0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                state_r[c] <= state_nxt_s[c];
                cnt_r[c]   <= cnt_nxt_s[c];
                if (accept_s[c]) begin
                    snap_r[c] <= rd_word_s[c];
                end else begin
                    snap_r[c] <= snap_r[c];
                end
                M_Rdata_ram[c*DATA_W +: DATA_W] <= rdata_nxt_s[c];
            end
            kind_r    <= kind_nxt_s;
            M_DataRdy <= rdy_nxt_s;
            err_flag  <= err_flag | (|err_req_s) | err_load_s;
        end
    end

    // Array update; later assignments win, so channel writes beat preload and higher channels beat lower.
    always_ff @(posedge clock) begin
        if (load_en && !err_load_s) begin
            mem_r[IDX_W'(load_addr)] <= load_data;
        end
        for (int c = 0; c < N_CH; c++) begin
            for (int i = 0; i < NB; i++) begin
                if (accept_s[c] && Mout_we_ram[c] && (SIZE_W'(i) < nb_s[c])) begin
                    mem_r[IDX_W'(off_s[c] + ADDR_W'(i))] <= Mout_Wdata_ram[c*DATA_W + 8*i +: 8];
                end
            end
        end
    end

endmodule
